mul8_seq_ctrl: RTL and testbench

MUL8_SEQ_CTRL -- requirements
Module: mul8_seq_ctrl

---
 rtl/mul8_seq_ctrl.sv | 110 +++++++++++
 tb/tb_mul8_seq_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier controller driving an external 4x4 array multiplier.
// Optional build macro MUL8_SEQ_ZERO_SKIP_EN: zero operands bypass the passes and finish at once.
module mul8_seq_ctrl #(
  parameter int unsigned MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [15:0] p,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int unsigned WW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MUL_LAT);

  state_t         state, state_nxt;
  logic [7:0]     op_a, op_b;
  logic [15:0]    acc, p_q, term;
  logic [1:0]     pass;
  logic [WW-1:0]  wcnt;
  logic           accept, pass_end, zero_skip;

  assign accept   = start_valid && start_ready;
  assign pass_end = (state == RUN) && (wcnt == WAIT_LAST);

`ifdef MUL8_SEQ_ZERO_SKIP_EN
  assign zero_skip = (a == 8'd0) || (b == 8'd0);
`else
  assign zero_skip = 1'b0;
`endif

  // Pass order k0..k3: bit0 of the pass selects the a nibble, bit1 the b nibble.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state == RUN) begin
      mul_a = pass[0] ? op_a[7:4] : op_a[3:0];
      mul_b = pass[1] ? op_b[7:4] : op_b[3:0];
    end
  end

  always_comb begin
    term = '0;
    case (pass)
      2'd0:    term = {8'h00, mul_p};
      2'd1,
      2'd2:    term = {4'h0, mul_p, 4'h0};
      default: term = {mul_p, 8'h00};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    start_ready  = (state == IDLE) && !rst;
    result_valid = (state == DONE);
    busy         = (state != IDLE);
    case (state)
      IDLE: if (accept) state_nxt = zero_skip ? DONE : RUN;
      RUN:  if (pass_end && (pass == 2'd3)) state_nxt = DONE;
      DONE: if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
      acc  <= '0;
      p_q  <= '0;
      pass <= '0;
      wcnt <= '0;
    end else if (accept) begin
      op_a <= a;
      op_b <= b;
      acc  <= '0;
      pass <= '0;
      wcnt <= '0;
      if (zero_skip) p_q <= '0;
    end else if (state == RUN) begin
      if (pass_end) begin
        wcnt <= '0;
        pass <= pass + 2'd1;
        acc  <= acc + term;
        // p only changes when a product completes, so it holds the last result in IDLE.
        if (pass == 2'd3) p_q <= acc + term;
      end else begin
        wcnt <= wcnt + WW'(1);
      end
    end
  end

  assign p = p_q;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Bench for mul8_seq_ctrl: one instance with MUL_LAT=0 and one with MUL_LAT=2, each with a multiplier model.
// Expected products go through a scoreboard queue; latency and nibble sequencing are checked per cycle.
module tb_mul8_seq_ctrl;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       sv, sr, rv, rr, bz;
  logic [1:0][7:0]  a_in, b_in, mp;
  logic [1:0][3:0]  ma, mb;
  logic [1:0][15:0] pr;
  logic [7:0]       pp1, pp2;

  int checks   = 0;
  int failures = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  mul8_seq_ctrl #(.MUL_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start_valid(sv[0]), .start_ready(sr[0]),
    .a(a_in[0]), .b(b_in[0]), .mul_a(ma[0]), .mul_b(mb[0]), .mul_p(mp[0]),
    .result_valid(rv[0]), .result_ready(rr[0]), .p(pr[0]), .busy(bz[0])
  );

  mul8_seq_ctrl #(.MUL_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start_valid(sv[1]), .start_ready(sr[1]),
    .a(a_in[1]), .b(b_in[1]), .mul_a(ma[1]), .mul_b(mb[1]), .mul_p(mp[1]),
    .result_valid(rv[1]), .result_ready(rr[1]), .p(pr[1]), .busy(bz[1])
  );

  assign mp[0] = 8'(ma[0]) * 8'(mb[0]);

  always @(posedge clk) begin
    pp1 <= 8'(ma[1]) * 8'(mb[1]);
    pp2 <= pp1;
  end
  assign mp[1] = pp2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input int d, input logic [7:0] aa, input logic [7:0] bb, input int hold);
    int lat, per, n, w;
    bit got, skip;
    logic [3:0] ea, eb;
    logic [15:0] expp;
    per  = (d == 0) ? 1 : 3;
    skip = 1'b0;
`ifdef MUL8_SEQ_ZERO_SKIP_EN
    skip = (aa == 8'd0) || (bb == 8'd0);
`endif
    lat = skip ? 1 : 4 * per + 1;
    w = 0;
    while (!sr[d] && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("start_ready_wait", 32'(sr[d]), 32'd1);
    sv[d] = 1'b1;
    a_in[d] = aa;
    b_in[d] = bb;
    @(posedge clk);
    sb_q.push_back(16'(aa) * 16'(bb));
    #1;
    sv[d] = 1'b0;
    a_in[d] = 8'($urandom);
    b_in[d] = 8'($urandom);
    n = 0;
    got = 1'b0;
    while (!got && n < lat + 5) begin
      @(negedge clk);
      n++;
      if (rv[d]) got = 1'b1;
      else if (n < lat) begin
        ea = ((n - 1) / per) % 2 == 1 ? aa[7:4] : aa[3:0];
        eb = ((n - 1) / per) >= 2 ? bb[7:4] : bb[3:0];
        chk("mul_a_seq", 32'(ma[d]), 32'(ea));
        chk("mul_b_seq", 32'(mb[d]), 32'(eb));
        chk("busy_run", 32'(bz[d]), 32'd1);
        // Requester inputs must be ignored mid-operation.
        sv[d] = 1'b1;
      end
    end
    sv[d] = 1'b0;
    chk("result_valid_seen", 32'(got), 32'd1);
    chk("latency", 32'(n), 32'(lat));
    if (sb_q.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
      expp = '0;
    end else expp = sb_q.pop_front();
    chk("product", 32'(pr[d]), 32'(expp));
    chk("mul_a_done", 32'(ma[d]), 32'd0);
    chk("mul_b_done", 32'(mb[d]), 32'd0);
    chk("start_ready_done", 32'(sr[d]), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("valid_hold", 32'(rv[d]), 32'd1);
      chk("p_hold", 32'(pr[d]), 32'(expp));
      chk("start_ready_hold", 32'(sr[d]), 32'd0);
    end
    rr[d] = 1'b1;
    @(negedge clk);
    rr[d] = 1'b0;
    chk("valid_after_hs", 32'(rv[d]), 32'd0);
    chk("start_ready_after_hs", 32'(sr[d]), 32'd1);
    chk("busy_after_hs", 32'(bz[d]), 32'd0);
    chk("p_idle_hold", 32'(pr[d]), 32'(expp));
  endtask

  initial begin
    rst = 1'b1;
    sv = '0; rr = '0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_start_ready", 32'(sr[d]), 32'd0);
      chk("rst_valid", 32'(rv[d]), 32'd0);
      chk("rst_busy", 32'(bz[d]), 32'd0);
      chk("rst_p", 32'(pr[d]), 32'd0);
      chk("rst_mul_a", 32'(ma[d]), 32'd0);
      chk("rst_mul_b", 32'(mb[d]), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("start_ready_after_rst0", 32'(sr[0]), 32'd1);
    chk("start_ready_after_rst2", 32'(sr[1]), 32'd1);
    @(negedge clk);

    run_txn(0, 8'h0F, 8'h0F, 0);
    run_txn(0, 8'hFF, 8'hFF, 0);
    run_txn(0, 8'hA7, 8'h5C, 3);
    run_txn(1, 8'h12, 8'h34, 0);
    run_txn(1, 8'hFF, 8'hFF, 1);
    run_txn(1, 8'h9B, 8'hE4, 0);

    // Abort a transaction with reset in its second RUN cycle.
    sv[0] = 1'b1; a_in[0] = 8'h55; b_in[0] = 8'h66;
    @(posedge clk);
    #1 sv[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_start_ready", 32'(sr[0]), 32'd0);
    chk("abort_valid", 32'(rv[0]), 32'd0);
    chk("abort_busy", 32'(bz[0]), 32'd0);
    chk("abort_p", 32'(pr[0]), 32'd0);
    chk("abort_mul_a", 32'(ma[0]), 32'd0);
    chk("abort_mul_b", 32'(mb[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_start_ready_after", 32'(sr[0]), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(rv[0]), 32'd0);
    end
    run_txn(0, 8'h10, 8'h10, 0);

    run_txn(0, 8'h00, 8'hAB, 0);
    run_txn(1, 8'h37, 8'h00, 2);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
